ps2_host_tx: RTL and testbench

//   Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_host_tx_pkg.sv | 39 +++
 rtl/ps2_host_tx_if.sv | 28 ++
 rtl/ps2_line_sync.sv | 49 ++++
 rtl/ps2_host_tx.sv | 170 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ============================================================================
// Module : ps2_host_tx_pkg
// Brief  : Shared PS/2 host-transmit types, command bytes and helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERROR     = 3'd7
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  // Data bits + parity + stop; the start bit is driven during REQ.
  localparam int unsigned PS2_FRAME_BITS = 10;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
// ============================================================================
// Module : ps2_host_tx_if
// Brief  : Command-byte handshake and status between a client and ps2_host_tx.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       err_timeout;
  logic       busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, tx_error, err_timeout, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, tx_error, err_timeout, busy
  );
endinterface

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ============================================================================
// Module : ps2_line_sync
// Brief  : Synchronizes raw ps2_clk/ps2_data and flags ps2_clk falling edges.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic sync_clk,
  output logic sync_data,
  output logic clk_fall
);

  logic [SYNC_STAGES-1:0] clk_pipe_q, clk_pipe_d;
  logic [SYNC_STAGES-1:0] data_pipe_q, data_pipe_d;
  logic                   clk_prev_q, clk_prev_d;

  always_comb begin
    clk_pipe_d  = {clk_pipe_q[SYNC_STAGES-2:0], ps2_clk_in};
    data_pipe_d = {data_pipe_q[SYNC_STAGES-2:0], ps2_data_in};
    clk_prev_d  = clk_pipe_q[SYNC_STAGES-1];
  end

  // Idle PS/2 lines float high, so the pipeline resets to 1 to avoid a bogus fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_pipe_q  <= '1;
      data_pipe_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_pipe_q  <= clk_pipe_d;
      data_pipe_q <= data_pipe_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  assign sync_clk  = clk_pipe_q[SYNC_STAGES-1];
  assign sync_data = data_pipe_q[SYNC_STAGES-1];
  assign clk_fall  = clk_prev_q & ~sync_clk;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module : ps2_host_tx
// Brief  : PS/2 host-to-device command transmitter with ACK check and timeout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic           clk,
  input  logic           reset,
  ps2_host_tx_if.slave   tx,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);

  localparam int unsigned INH_W = cnt_width(INHIBIT_CYCLES);
  localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_FALL = 4'(PS2_FRAME_BITS - 1);

  ps2_tx_state_e state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             err_tmo_q, err_tmo_d;

  logic sync_clk, sync_data, clk_fall;
  logic tmo_active, tmo_hit;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .sync_clk    (sync_clk),
    .sync_data   (sync_data),
    .clk_fall    (clk_fall)
  );

  assign tmo_active = (state_q == ST_SHIFT) || (state_q == ST_ACK) ||
                      (state_q == ST_WAIT_IDLE);
  assign tmo_hit    = tmo_active && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    err_tmo_d = 1'b0;

    if (tmo_active && !tmo_hit) tmo_cnt_d = tmo_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx.tx_valid) begin
          state_d   = ST_INHIBIT;
          shift_d   = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = ST_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      ST_REQ: begin
        clk_oe_d  = 1'b0;
        tmo_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tmo_hit) begin
          data_oe_d = 1'b0;
          err_tmo_d = 1'b1;
          state_d   = ST_ERROR;
        end else if (clk_fall) begin
          // The stop bit is a 1 in the shift word, so fall 10 releases data.
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_FALL) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = ST_ERROR;
        end else if (clk_fall) begin
          state_d = sync_data ? ST_ERROR : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = ST_ERROR;
        end else if (sync_clk && sync_data) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  assign ps2_clk_oe     = clk_oe_q;
  assign ps2_data_oe    = data_oe_q;
  assign tx.tx_ready    = (state_q == ST_IDLE);
  assign tx.busy        = (state_q != ST_IDLE);
  assign tx.tx_done     = (state_q == ST_DONE);
  assign tx.tx_error    = (state_q == ST_ERROR);
  assign tx.err_timeout = err_tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
// Module : tb_ps2_host_tx
// Brief  : Directed bench for ps2_host_tx with a simple PS/2 device model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 1000;
  localparam int SYNC = 2;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk_oe, ps2_data_oe;
  logic bfm_clk  = 1'b1;
  logic bfm_data = 1'b1;
  logic ps2_clk_in, ps2_data_in;

  always #5 clk = ~clk;

  assign ps2_clk_in  = bfm_clk  & ~ps2_clk_oe;
  assign ps2_data_in = bfm_data & ~ps2_data_oe;

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tx          (tx_if),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  int done_cnt = 0, err_cnt = 0, oe_run = 0, oe_len = 0, ready_hi = 0;
  bit mon_ready = 1'b0;

  always @(negedge clk) begin
    if (tx_if.tx_done)  done_cnt++;
    if (tx_if.tx_error) err_cnt++;
    if (ps2_clk_oe) oe_run++;
    else if (oe_run != 0) begin
      oe_len = oe_run;
      oe_run = 0;
    end
    if (mon_ready && tx_if.tx_ready) ready_hi++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic half_period();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  // Returns at the first negedge after the host releases ps2_clk.
  task automatic wait_release();
    int n = 0;
    while (!ps2_clk_oe && n < 200) begin @(negedge clk); n++; end
    while (ps2_clk_oe && n < 400) begin @(negedge clk); n++; end
    if (n >= 200) check_eq("release_seen", 0, 1);
  endtask

  // bits[0]=start, bits[8:1]=data, bits[9]=parity, bits[10]=stop
  task automatic bfm_frame(output logic [10:0] bits);
    wait_release();
    half_period();
    bits[0] = ps2_data_in;
    for (int i = 1; i <= 10; i++) begin
      bfm_clk = 1'b0;
      half_period();
      bfm_clk = 1'b1;
      bits[i] = ps2_data_in;
      half_period();
    end
  endtask

  task automatic bfm_ack();
    bfm_data = 1'b0;
    half_period();
    bfm_clk = 1'b0;
    half_period();
    bfm_clk = 1'b1;
    repeat (4) @(negedge clk);
    bfm_data = 1'b1;
  endtask

  task automatic wait_result(output bit got_done, output bit got_err);
    int n = 0;
    got_done = 1'b0;
    got_err  = 1'b0;
    while (!got_done && !got_err && n < 3000) begin
      @(negedge clk);
      n++;
      got_done = tx_if.tx_done;
      got_err  = tx_if.tx_error;
    end
    if (!got_done && !got_err) check_eq("result_seen", 0, 1);
  endtask

  initial begin
    logic [10:0] bits, bits_b;
    bit d, e;
    int d0, e0, n;

    reset          = 1'b0;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    check_eq("rst_ready",   tx_if.tx_ready,    1);
    check_eq("rst_busy",    tx_if.busy,        0);
    check_eq("rst_done",    tx_if.tx_done,     0);
    check_eq("rst_error",   tx_if.tx_error,    0);
    check_eq("rst_errtmo",  tx_if.err_timeout, 0);
    check_eq("rst_clk_oe",  ps2_clk_oe,        0);
    check_eq("rst_data_oe", ps2_data_oe,       0);

    // 0xED set-LEDs, ACKed
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    check_eq("ed_busy", tx_if.busy, 1);
    bfm_frame(bits);
    bfm_ack();
    wait_result(d, e);
    repeat (5) @(negedge clk);
    check_eq("ed_start",  bits[0],     0);
    check_eq("ed_data",   bits[8:1],   8'hED);
    check_eq("ed_parity", bits[9],     1);
    check_eq("ed_stop",   bits[10],    1);
    check_eq("ed_done",   done_cnt - d0, 1);
    check_eq("ed_error",  err_cnt - e0,  0);
    check_eq("ed_inhibit_len", oe_len, INH + 1);

    // Parity edge cases
    start_tx(8'h00);
    bfm_frame(bits);
    bfm_ack();
    wait_result(d, e);
    check_eq("p00_data",   bits[8:1], 8'h00);
    check_eq("p00_parity", bits[9],   1);
    check_eq("p00_inhibit_len", oe_len, INH + 1);
    check_eq("p00_done", d, 1);

    start_tx(8'h01);
    bfm_frame(bits);
    bfm_ack();
    wait_result(d, e);
    check_eq("p01_data",   bits[8:1], 8'h01);
    check_eq("p01_parity", bits[9],   0);
    check_eq("p01_inhibit_len", oe_len, INH + 1);

    // NACK: data left high in the ACK slot
    start_tx(8'h55);
    bfm_frame(bits);
    bfm_clk = 1'b0;
    wait_result(d, e);
    check_eq("nack_error",   e,                 1);
    check_eq("nack_errtmo",  tx_if.err_timeout, 0);
    check_eq("nack_clk_oe",  ps2_clk_oe,        0);
    check_eq("nack_data_oe", ps2_data_oe,       0);
    @(negedge clk);
    check_eq("nack_ready_next", tx_if.tx_ready, 1);
    half_period();
    bfm_clk = 1'b1;
    repeat (10) @(negedge clk);

    // Timeout: device never clocks
    start_tx(8'hF4);
    wait_release();
    n = 0;
    while (!tx_if.tx_error && n < TMO + 50) begin @(negedge clk); n++; end
    check_eq("tmo_latency", n, TMO);
    check_eq("tmo_error",   tx_if.tx_error,    1);
    check_eq("tmo_errtmo",  tx_if.err_timeout, 1);
    check_eq("tmo_data_oe", ps2_data_oe,       0);
    repeat (5) @(negedge clk);

    // tx_valid held with a new byte during a transfer
    d0 = done_cnt;
    @(negedge clk);
    tx_if.tx_data  = 8'h3C;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_data = 8'hC3;
    mon_ready     = 1'b1;
    bfm_frame(bits);
    bfm_ack();
    wait_result(d, e);
    mon_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    bfm_frame(bits_b);
    bfm_ack();
    wait_result(d, e);
    repeat (3) @(negedge clk);
    check_eq("hold_first",    bits[8:1],   8'h3C);
    check_eq("hold_second",   bits_b[8:1], 8'hC3);
    check_eq("hold_ready_hi", ready_hi,    0);
    check_eq("hold_done",     done_cnt - d0, 2);

    // Reset after fall 5, then a normal 0xFF
    start_tx(8'h0F);
    wait_release();
    half_period();
    for (int i = 1; i <= 4; i++) begin
      bfm_clk = 1'b0;
      half_period();
      bfm_clk = 1'b1;
      half_period();
    end
    bfm_clk = 1'b0;
    half_period();
    check_eq("rst5_data_oe_before", ps2_data_oe, 1);
    d0 = done_cnt; e0 = err_cnt;
    #2 reset = 1'b0;
    #1;
    check_eq("rst5_clk_oe",  ps2_clk_oe,  0);
    check_eq("rst5_data_oe", ps2_data_oe, 0);
    @(negedge clk);
    bfm_clk = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("rst5_no_done",  done_cnt - d0, 0);
    check_eq("rst5_no_error", err_cnt - e0,  0);
    check_eq("rst5_ready",    tx_if.tx_ready, 1);

    start_tx(8'hFF);
    bfm_frame(bits);
    bfm_ack();
    wait_result(d, e);
    check_eq("ff_data",   bits[8:1], 8'hFF);
    check_eq("ff_parity", bits[9],   1);
    check_eq("ff_done",   d,         1);
    check_eq("ff_error",  e,         0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
